// File: rtl/if_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg -- shared types and constants for the RV32I instruction-fetch stage.
//   NOP_INSTR           : canonical bubble encoding (addi x0, x0, 0)
//   HALT_INSTR_DEFAULT  : default stop-fetch encoding (ECALL)
//   fetch_state_t       : fetch FSM states BOOT / RUN / HALT
//   if_id_t             : contents of the IF/ID pipeline register
//   if_id_bubble()      : builds an IF/ID bubble value
// ---------------------------------------------------------------------------
package if_pkg;

  localparam logic [31:0] NOP_INSTR          = 32'h0000_0013;
  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'h0000_0073;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  // A bubble carries a NOP with zeroed PCs so downstream stages see nothing.
  function automatic if_id_t if_id_bubble();
    if_id_t b;
    b.instr    = NOP_INSTR;
    b.pc       = 32'h0;
    b.pc_plus4 = 32'h0;
    b.valid    = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg -- generic stage register with priority reset > flush > stall > load.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; loads a bubble
//   flush : load a bubble
//   stall : hold current contents
//   d     : value loaded when neither flush nor stall is asserted
//   q     : registered contents
// ---------------------------------------------------------------------------
module if_id_reg
  import if_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   flush,
  input  logic   stall,
  input  if_id_t d,
  output if_id_t q
);

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples pre-edge values regardless of process order.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= if_id_bubble();
    end else if (flush) begin
      q <= if_id_bubble();
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage -- RV32I instruction-fetch stage: PC register, IF/ID register,
// stall/flush/redirect handling and a BOOT/RUN/HALT state machine that stops
// fetch on ECALL or on an out-of-range / misaligned fetch address.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   stall_f, stall_d      : hold PC / hold IF/ID
//   flush_d               : replace IF/ID with a bubble
//   pc_src_e, pc_target_e : redirect request and target from execute
//   imem_addr, imem_rd    : combinational instruction memory interface
//   instr_d, pc_d, pc_plus4_d, valid_d : IF/ID register outputs
//   halted                : FSM is in HALT
//   fetch_err             : sticky bad-fetch flag, cleared only by reset
//
// Build option: defining IF_PERF_CNT_EN adds the fetch_cnt and stall_cnt
// performance counter outputs.
// ---------------------------------------------------------------------------
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 64,
  parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic        halted,
  output logic        fetch_err
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  fetch_state_t state, state_next;
  logic [31:0]  pc_f, pc_next, pc_plus4_f;
  logic         bad_fetch;
  logic         halt_fetch;
  logic         load_valid;
  logic         err_set;
  logic         ifid_flush, ifid_stall;
  if_id_t       ifid_d, ifid_q;

  assign pc_plus4_f = pc_f + 32'd4;  // wraps modulo 2^32
  assign imem_addr  = pc_f;
  assign bad_fetch  = (pc_f[1:0] != 2'b00) ||
                      ({2'b00, pc_f[31:2]} >= 32'(IMEM_WORDS));

  // A RUN-state edge that actually captures imem_rd into IF/ID as valid.
  assign load_valid = (state == RUN) && !flush_d && !stall_d && !bad_fetch;
  // The halting word only stops fetch on the correct path (no redirect).
  assign halt_fetch = load_valid && !pc_src_e && (imem_rd == HALT_INSTR);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    pc_next    = pc_f;
    ifid_flush = 1'b0;
    ifid_stall = 1'b0;
    err_set    = 1'b0;
    ifid_d     = '{instr: imem_rd, pc: pc_f, pc_plus4: pc_plus4_f, valid: 1'b1};

    unique case (state)
      BOOT: begin
        ifid_flush = 1'b1;
        state_next = RUN;
      end

      RUN: begin
        if (pc_src_e)     pc_next = pc_target_e;
        else if (!stall_f) pc_next = pc_plus4_f;

        ifid_flush = flush_d;
        ifid_stall = stall_d;

        if (bad_fetch) begin
          // Never hand an out-of-range word downstream; park on the bad address.
          ifid_d     = if_id_bubble();
          err_set    = 1'b1;
          state_next = HALT;
          if (!pc_src_e) pc_next = pc_f;
        end else if (halt_fetch) begin
          state_next = HALT;
          pc_next    = pc_f;
        end
      end

      HALT: begin
        if (pc_src_e) begin
          // Leaving a wrong-path halt: restart at the target with a clean IF/ID.
          pc_next    = pc_target_e;
          state_next = RUN;
          ifid_flush = 1'b1;
        end else begin
          ifid_flush = !stall_d;
          ifid_stall = stall_d;
        end
      end

      default: begin
        state_next = BOOT;
        ifid_flush = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= BOOT;
      pc_f      <= RESET_PC;
      fetch_err <= 1'b0;
    end else begin
      state     <= state_next;
      pc_f      <= pc_next;
      if (err_set) fetch_err <= 1'b1;
    end
  end

  if_id_reg u_if_id_reg (
    .clk   (clk),
    .reset (reset),
    .flush (ifid_flush),
    .stall (ifid_stall),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign instr_d    = ifid_q.instr;
  assign pc_d       = ifid_q.pc;
  assign pc_plus4_d = ifid_q.pc_plus4;
  assign valid_d    = ifid_q.valid;
  assign halted     = (state == HALT);

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt <= 32'h0;
      stall_cnt <= 32'h0;
    end else begin
      if (load_valid) fetch_cnt <= fetch_cnt + 32'd1;
      if ((state == RUN) && stall_f && !pc_src_e) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage -- directed bench for if_fetch_stage. A behavioural model
// advances on every rising edge from the fetch rules; a negedge process
// compares all outputs against it, and the directed sequence pins the model
// with hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_f, stall_d, flush_d, pc_src_e;
  logic [31:0] pc_target_e;
  logic [31:0] imem_addr, imem_rd;
  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic        valid_d, halted, fetch_err;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt;
`endif

  logic [31:0] mem [64];

  int checks = 0;
  int errors = 0;
  bit started = 0;

  always #5 clk = ~clk;

  assign imem_rd = (imem_addr[31:8] == 24'h0) ? mem[imem_addr[7:2]] : 32'hDEAD_BEEF;

  if_fetch_stage #(
    .RESET_PC   (32'h0),
    .IMEM_WORDS (64),
    .HALT_INSTR (ECALL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .pc_src_e    (pc_src_e),
    .pc_target_e (pc_target_e),
    .imem_addr   (imem_addr),
    .imem_rd     (imem_rd),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pc_plus4_d  (pc_plus4_d),
    .valid_d     (valid_d),
    .halted      (halted),
    .fetch_err   (fetch_err)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4;
  logic        m_valid, m_err;
  logic [31:0] m_fcnt, m_scnt;
  int          m_mode;  // 0 = first cycle after reset, 1 = fetching, 2 = stopped

  task automatic m_bubble();
    m_instr = NOP; m_pcd = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
  endtask

  always @(posedge clk) begin
    logic [31:0] nxt;
    logic [31:0] word;
    bit          bad;
    if (reset) begin
      m_pc = 32'h0; m_bubble(); m_mode = 0; m_err = 0; m_fcnt = 0; m_scnt = 0;
    end else if (m_mode == 0) begin
      m_bubble(); m_mode = 1;
    end else if (m_mode == 2) begin
      if (pc_src_e) begin
        m_pc = pc_target_e; m_bubble(); m_mode = 1;
      end else if (!stall_d) begin
        m_bubble();
      end
    end else begin
      bad = (m_pc % 4 != 0) || (m_pc / 4 >= 64);
      nxt = pc_src_e ? pc_target_e : (stall_f ? m_pc : m_pc + 32'd4);
      if (stall_f && !pc_src_e) m_scnt++;
      if (bad) begin
        m_err = 1; m_mode = 2;
        if (!pc_src_e) nxt = m_pc;
        if (flush_d || !stall_d) m_bubble();
      end else if (flush_d) begin
        m_bubble();
      end else if (!stall_d) begin
        word = mem[m_pc / 4];
        m_instr = word; m_pcd = m_pc; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
        m_fcnt++;
        if (word == ECALL && !pc_src_e) begin
          m_mode = 2; nxt = m_pc;
        end
      end
      m_pc = nxt;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      check("imem_addr",  imem_addr,  m_pc);
      check("instr_d",    instr_d,    m_instr);
      check("pc_d",       pc_d,       m_pcd);
      check("pc_plus4_d", pc_plus4_d, m_pc4);
      check("valid_d",    {31'h0, valid_d},   {31'h0, m_valid});
      check("halted",     {31'h0, halted},    {31'h0, (m_mode == 2)});
      check("fetch_err",  {31'h0, fetch_err}, {31'h0, m_err});
`ifdef IF_PERF_CNT_EN
      check("fetch_cnt",  fetch_cnt,  m_fcnt);
      check("stall_cnt",  stall_cnt,  m_scnt);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    started = 1;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    pc_src_e = 1; pc_target_e = tgt;
    tick();
    pc_src_e = 0; pc_target_e = 32'h0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = NOP;
    mem[0] = 32'h0003_A437;
    mem[1] = 32'h7D04_0413;
    mem[5] = ECALL;
    mem[8] = 32'h0010_0093;

    reset = 1; stall_f = 0; stall_d = 0; flush_d = 0; pc_src_e = 0; pc_target_e = 0;
    tick(); tick();
    check("rst_valid", {31'h0, valid_d}, 32'h0);
    check("rst_instr", instr_d, NOP);
    reset = 0;

    tick();  // boot cycle
    check("boot_valid", {31'h0, valid_d}, 32'h0);
    check("boot_addr",  imem_addr, 32'h0);
    tick();
    check("f0_instr", instr_d, 32'h0003_A437);
    check("f0_pc",    pc_d,    32'h0);
    tick();
    check("f1_instr", instr_d, 32'h7D04_0413);
    check("f1_pc",    pc_d,    32'h4);
    check("f1_valid", {31'h0, valid_d}, 32'h1);

    stall_f = 1; stall_d = 1;
    tick(); tick();
    check("stall_addr", imem_addr, 32'h8);
    check("stall_pc_d", pc_d,      32'h4);
    stall_f = 0; stall_d = 0;
    tick();
    check("unstall_pc_d", pc_d, 32'h8);

    stall_f = 1; flush_d = 1;
    redirect(32'h20);
    stall_f = 0; flush_d = 0;
    check("redir_addr",  imem_addr, 32'h20);
    check("redir_instr", instr_d,   NOP);
    check("redir_valid", {31'h0, valid_d}, 32'h0);
    tick();
    check("tgt_instr", instr_d, 32'h0010_0093);
    check("tgt_pc",    pc_d,    32'h20);

    redirect(32'h10);
    tick();
    tick();
    check("halt_instr", instr_d, ECALL);
    check("halt_valid", {31'h0, valid_d}, 32'h1);
    check("halt_flag",  {31'h0, halted},  32'h1);
    check("halt_addr",  imem_addr, 32'h14);
    tick();
    check("halt_bubble", instr_d, NOP);
    check("halt_hold",   imem_addr, 32'h14);
    redirect(32'h0);
    check("unhalt_flag", {31'h0, halted}, 32'h0);
    check("unhalt_addr", imem_addr, 32'h0);
    tick();
    check("resume_instr", instr_d, 32'h0003_A437);

    redirect(32'h100);
    tick();
    check("oor_err",   {31'h0, fetch_err}, 32'h1);
    check("oor_halt",  {31'h0, halted},    32'h1);
    check("oor_valid", {31'h0, valid_d},   32'h0);
    redirect(32'h0);
    check("sticky_err",  {31'h0, fetch_err}, 32'h1);
    check("sticky_halt", {31'h0, halted},    32'h0);
    tick();
    redirect(32'h6);
    tick();
    check("mis_err",   {31'h0, fetch_err}, 32'h1);
    check("mis_halt",  {31'h0, halted},    32'h1);
    check("mis_instr", instr_d, NOP);

    // Reset in the middle of activity overrides every other input.
    reset = 1; pc_src_e = 1; pc_target_e = 32'h40; flush_d = 1; stall_f = 1;
    tick();
    check("mrst_addr",  imem_addr, 32'h0);
    check("mrst_err",   {31'h0, fetch_err}, 32'h0);
    check("mrst_halt",  {31'h0, halted},    32'h0);
    check("mrst_valid", {31'h0, valid_d},   32'h0);
    reset = 0; pc_src_e = 0; pc_target_e = 0; flush_d = 0; stall_f = 0;

    tick();                  // boot
    tick(); tick();          // fetch words 0, 1
    stall_f = 1; stall_d = 1;
    tick(); tick(); tick();  // three stall cycles
    stall_f = 0; stall_d = 0;
    tick(); tick(); tick();  // fetch words 2, 3, 4
    check("run_pc_d", pc_d,      32'h10);
    check("run_addr", imem_addr, 32'h14);
`ifdef IF_PERF_CNT_EN
    check("perf_fetch", fetch_cnt, 32'd5);
    check("perf_stall", stall_cnt, 32'd3);
    reset = 1;
    tick();
    check("perf_fetch_rst", fetch_cnt, 32'd0);
    check("perf_stall_rst", stall_cnt, 32'd0);
    reset = 0;
`endif
    tick();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
